// File: rtl/debug_link_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debug_link_pkg
// Brief    : Shared constants and state encoding for the debug serial link.
// Revision : 1.0 - initial release
// ============================================================================
package debug_link_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_BYTES       = 9;
    localparam int         BITS_PER_BYTE     = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } link_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_byte_tx
// Brief    : One-byte 8N1 serializer, LSB first, with back-to-back reload.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import debug_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       byte_done,
    output logic       tx
);

    localparam int                    c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    link_state_t         r_state,  w_state_nxt;
    logic [c_BAUD_W-1:0] r_baud,   w_baud_nxt;
    logic [2:0]          r_bit,    w_bit_nxt;
    logic [7:0]          r_shift,  w_shift_nxt;
    logic                r_tx,     w_tx_nxt;
    logic                w_bit_end;

    assign w_bit_end  = (r_baud == c_BAUD_LAST);
    assign byte_done  = (r_state == STOP_BIT) && w_bit_end;
    // Accepting at the end of a stop bit removes any idle gap between bytes.
    assign byte_ready = (r_state == IDLE) || byte_done;
    assign tx         = r_tx;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_baud_nxt  = ((r_state == IDLE) || w_bit_end) ? '0 : r_baud + 1'b1;
        case (r_state)
            IDLE: begin
                if (byte_valid) begin
                    w_state_nxt = START_BIT;
                    w_shift_nxt = byte_data;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = 1'b0;
                end
            end
            START_BIT: begin
                if (w_bit_end) begin
                    w_state_nxt = DATA_BITS;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            DATA_BITS: begin
                if (w_bit_end) begin
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP_BIT;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            STOP_BIT: begin
                if (w_bit_end) begin
                    if (byte_valid) begin
                        w_state_nxt = START_BIT;
                        w_shift_nxt = byte_data;
                        w_bit_nxt   = 3'd0;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/debug_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : debug_uart_tx
// Brief    : Snapshots the seven CPU debug ports and sends them as one framed
//            UART packet: sync, seven data bytes, 8-bit modular checksum.
// Revision : 1.0 - initial release
// ============================================================================
module debug_uart_tx
    import debug_link_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [3:0] c_LAST_IDX = 4'(FRAME_BYTES - 1);

    logic [7:0] r_snap [7];
    logic [7:0] r_chk;
    logic [3:0] r_idx;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_last;
    logic [3:0] w_next_idx;
    logic [7:0] w_port_sum;
    logic       w_byte_valid;
    logic       w_byte_ready;
    logic       w_byte_done;
    logic [7:0] w_byte_data;

    assign w_accept     = !r_busy && start;
    assign w_last       = (r_idx == c_LAST_IDX);
    assign w_next_idx   = r_busy ? (r_idx + 4'd1) : 4'd0;
    assign w_byte_valid = w_accept || (r_busy && !w_last);
    assign w_port_sum   = debug_port1 + debug_port2 + debug_port3 + debug_port4
                        + debug_port5 + debug_port6 + debug_port7;

    // The sync byte is a constant, so it can be offered on the very edge the
    // snapshot is taken; later bytes come from the snapshot and checksum.
    always_comb begin
        w_byte_data = SYNC_BYTE;
        if (w_next_idx >= c_LAST_IDX) begin
            w_byte_data = r_chk;
        end else if (w_next_idx != 4'd0) begin
            w_byte_data = r_snap[w_next_idx[2:0] - 3'd1];
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 7; i++) begin
                r_snap[i] <= 8'd0;
            end
            r_chk  <= 8'd0;
            r_idx  <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_snap[0] <= debug_port1;
                r_snap[1] <= debug_port2;
                r_snap[2] <= debug_port3;
                r_snap[3] <= debug_port4;
                r_snap[4] <= debug_port5;
                r_snap[5] <= debug_port6;
                r_snap[6] <= debug_port7;
                r_chk     <= w_port_sum;
                r_idx     <= 4'd0;
                r_busy    <= 1'b1;
            end else if (r_busy) begin
                if (w_byte_valid && w_byte_ready) begin
                    r_idx <= r_idx + 4'd1;
                end else if (w_byte_done && w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk        (clk),
        .nreset     (nreset),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .byte_ready (w_byte_ready),
        .byte_done  (w_byte_done),
        .tx         (tx)
    );

    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_debug_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_debug_uart_tx
// Brief    : Self-checking bench: cycle model of the serial line plus a UART
//            receiver checked against hand-computed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_uart_tx;

    localparam int CPB = 4;

    logic       clk    = 1'b0;
    logic       nreset = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] p [7];
    logic       tx;
    logic       busy;
    logic       frame_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debug_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .start       (start),
        .debug_port1 (p[0]),
        .debug_port2 (p[1]),
        .debug_port3 (p[2]),
        .debug_port4 (p[3]),
        .debug_port5 (p[4]),
        .debug_port6 (p[5]),
        .debug_port7 (p[6]),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Line model: a frame is a queue of per-cycle tx levels.
    bit   q_tx [$];
    logic exp_tx   = 1'b1;
    logic exp_busy = 1'b0;
    logic exp_done = 1'b0;

    task automatic push_byte(input logic [7:0] b);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++)
            for (int c = 0; c < CPB; c++)
                q_tx.push_back(bits[i]);
    endtask

    task automatic load_frame();
        int sum;
        sum = 0;
        push_byte(8'hA5);
        for (int i = 0; i < 7; i++) begin
            push_byte(p[i]);
            sum += int'(p[i]);
        end
        push_byte(sum[7:0]);
    endtask

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            q_tx.delete();
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (q_tx.size() > 0) begin
                void'(q_tx.pop_front());
                if (q_tx.size() == 0) exp_done = 1'b1;
            end else if (start) begin
                load_frame();
            end
            exp_busy = (q_tx.size() > 0);
            exp_tx   = exp_busy ? q_tx[0] : 1'b1;
        end
    end

    // Per-cycle compare, receiver and pulse/run monitors.
    int         cyc = 0;
    logic [7:0] rx_q [$];
    logic [7:0] rx_byte = 8'd0;
    bit         rx_active = 0;
    int         rx_cnt = 0;
    int         rx_k = 0;
    int         done_cnt = 0;
    int         last_done_cyc = 0;
    int         done_gap = 0;
    int         busy_run = 0;
    int         last_run = 0;

    always @(negedge clk) begin
        cyc++;
        n_vec++;
        if (tx !== exp_tx || busy !== exp_busy || frame_done !== exp_done) begin
            n_err++;
            $display("FAIL line cycle %0d: tx/busy/done got %b%b%b, expected %b%b%b",
                     cyc, tx, busy, frame_done, exp_tx, exp_busy, exp_done);
        end
        if (!nreset) begin
            rx_active = 0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                rx_k = rx_cnt / CPB;
                if (rx_k >= 1 && rx_k <= 8) begin
                    rx_byte[rx_k-1] = tx;
                end else if (rx_k == 9) begin
                    rx_q.push_back(rx_byte);
                    rx_active = 0;
                end
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_gap      = cyc - last_done_cyc;
            last_done_cyc = cyc;
        end
        if (busy === 1'b1) begin
            busy_run++;
        end else if (busy_run > 0) begin
            last_run = busy_run;
            busy_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (done_cnt < target && k < budget) begin
            step(1);
            k++;
        end
        if (done_cnt < target) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: frame_done count %0d, expected %0d", done_cnt, target);
        end
    endtask

    logic [7:0] e [9];

    task automatic check_frame(input string name, input int base);
        logic [7:0] got;
        for (int i = 0; i < 9; i++) begin
            got = 'x;
            if (base + i < rx_q.size()) got = rx_q[base + i];
            check($sformatf("%s[%0d]", name, i), 32'(got), 32'(e[i]));
        end
    endtask

    task automatic set_ports(input logic [7:0] first, input logic [7:0] incr);
        for (int i = 0; i < 7; i++) p[i] = first + incr * 8'(i);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    int base_done;

    initial begin
        set_ports(8'h00, 8'h00);
        nreset = 1'b0;
        start  = 1'b1;

        // Reset holds the line idle even with start requested.
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("reset_tx", 32'(tx), 32'd1);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_done", 32'(frame_done), 32'd0);
        end
        start = 1'b0;
        step(1);
        nreset = 1'b1;
        step(3);
        check("idle_tx", 32'(tx), 32'd1);

        // Basic frame.
        set_ports(8'h01, 8'h01);
        rx_q.delete();
        base_done = done_cnt;
        pulse_start();
        wait_done(base_done + 1, 500);
        step(5);
        e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C};
        check_frame("basic", 0);
        check("basic_nbytes", rx_q.size(), 32'd9);
        check("basic_busy_len", last_run, 32'd360);
        check("basic_done_cnt", done_cnt - base_done, 32'd1);

        // Snapshot holds; start during a frame is dropped.
        rx_q.delete();
        base_done = done_cnt;
        pulse_start();
        step(49);
        set_ports(8'hFF, 8'h00);
        pulse_start();
        wait_done(base_done + 1, 500);
        step(20);
        check_frame("snapshot", 0);
        check("snapshot_nbytes", rx_q.size(), 32'd9);
        check("snapshot_done_cnt", done_cnt - base_done, 32'd1);
        check("snapshot_idle_busy", 32'(busy), 32'd0);

        // Checksum wraps modulo 256.
        rx_q.delete();
        base_done = done_cnt;
        pulse_start();
        wait_done(base_done + 1, 500);
        step(5);
        e = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9};
        check_frame("wrap", 0);

        // Back-to-back frames with start held high.
        set_ports(8'd10, 8'd1);
        rx_q.delete();
        base_done = done_cnt;
        start = 1'b1;
        wait_done(base_done + 1, 500);
        step(3);
        start = 1'b0;
        wait_done(base_done + 2, 500);
        step(5);
        e = '{8'hA5, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd91};
        check_frame("b2b_first", 0);
        check_frame("b2b_second", 9);
        check("b2b_done_gap", done_gap, 32'd361);
        check("b2b_done_cnt", done_cnt - base_done, 32'd2);

        // Reset in the middle of byte 3 data bits aborts immediately.
        set_ports(8'h01, 8'h01);
        pulse_start();
        step(130);
        nreset = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        step(3);
        nreset = 1'b1;
        step(2);
        rx_q.delete();
        base_done = done_cnt;
        pulse_start();
        wait_done(base_done + 1, 500);
        step(5);
        e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h1C};
        check_frame("after_abort", 0);
        check("after_abort_busy_len", last_run, 32'd360);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
